// File: rtl/vec_decode_stage.sv
// Decode stage for the vector ASIP: scalar/vector register files, MEM/WB
// forwarding, load-use hazard detection and the ID/EX pipeline register.
module vec_decode_stage #(
   parameter int  LANES  = 4,
   parameter int  LANE_W = 32,
   parameter int  NREG   = 16,
   parameter int  NVREG  = 16,
   parameter int  RA_W   = 4,
   localparam int VW     = LANES * LANE_W
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            in_valid,
   input  logic [1:0]      op,
   input  logic [1:0]      inst,
   input  logic            flag_v,
   input  logic [RA_W-1:0] rd,
   input  logic [RA_W-1:0] rs1,
   input  logic [RA_W-1:0] rs2,
   input  logic [26:0]     imm,
   input  logic [31:0]     pc,
   input  logic            ex_stall,
   input  logic            flush,
   input  logic            mem_wreg,
   input  logic            mem_vf,
   input  logic [RA_W-1:0] mem_rd,
   input  logic [VW-1:0]   mem_data,
   input  logic            wb_en,
   input  logic            wb_vf,
   input  logic [RA_W-1:0] wb_rd,
   input  logic [VW-1:0]   wb_data,
   output logic            stall_o,
   output logic            out_valid,
   output logic            vf,
   output logic            wmem,
   output logic            rmem,
   output logic            wreg,
   output logic            cond_en,
   output logic [1:0]      jmp_f,
   output logic [2:0]      alu_op,
   output logic [VW-1:0]   opa,
   output logic [VW-1:0]   opb,
   output logic [VW-1:0]   opc,
   output logic [RA_W-1:0] rd_o
);

   typedef enum logic [1:0] {
      OP_ALU  = 2'b00,
      OP_ALUI = 2'b01,
      OP_MEM  = 2'b10,
      OP_JMP  = 2'b11
   } op_e;

   typedef struct packed {
      logic            valid;
      logic            vf;
      logic            wmem;
      logic            rmem;
      logic            wreg;
      logic            cond_en;
      logic [1:0]      jmp_f;
      logic [2:0]      alu_op;
      logic [RA_W-1:0] rd;
      logic [VW-1:0]   opa;
      logic [VW-1:0]   opb;
      logic [VW-1:0]   opc;
   } idex_t;

   function automatic logic [VW-1:0] pack_scalar(input logic [LANE_W-1:0] s);
      pack_scalar = '0;
      pack_scalar[VW-1 -: LANE_W] = s;
   endfunction

   logic [LANE_W-1:0] srf_q [NREG];
   logic [VW-1:0]     vrf_q [NVREG];

   // NOTE: register files are reset explicitly because the decode contract
   // requires every register to read 0 after reset, not just the pipeline.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NREG; i++)  srf_q[i] <= '0;
         for (int i = 0; i < NVREG; i++) vrf_q[i] <= '0;
      end else if (wb_en) begin
         if (wb_vf) begin
            if (int'(wb_rd) < NVREG) vrf_q[wb_rd] <= wb_data;
         end else if ((wb_rd != '0) && (int'(wb_rd) < NREG)) begin
            srf_q[wb_rd] <= wb_data[VW-1 -: LANE_W];
         end
      end
   end

   logic eff_vf, use_rs1, use_rs2;

   // NOTE: every combinational output gets a default before the case so no
   // path through the block leaves a variable unassigned (no latches).
   always_comb begin
      eff_vf  = 1'b0;
      use_rs1 = 1'b0;
      use_rs2 = 1'b0;
      case (op)
         OP_ALU:  begin eff_vf = flag_v; use_rs1 = 1'b1; use_rs2 = 1'b1; end
         OP_ALUI: use_rs1 = 1'b1;
         OP_MEM:  begin eff_vf = flag_v; use_rs1 = 1'b1; use_rs2 = inst[0]; end
         default: use_rs1 = (inst == 2'b10);
      endcase
   end

   // Source read: MEM forward beats WB bypass beats the register file.
   logic [VW-1:0] src_val [2];

   always_comb begin
      logic [RA_W-1:0] a;
      for (int s = 0; s < 2; s++) begin
         a          = (s == 0) ? rs1 : rs2;
         src_val[s] = '0;
         if (eff_vf) begin
            if (mem_wreg && mem_vf && (mem_rd == a))       src_val[s] = mem_data;
            else if (wb_en && wb_vf && (wb_rd == a))       src_val[s] = wb_data;
            else if (int'(a) < NVREG)                      src_val[s] = vrf_q[a];
         end else if (a != '0) begin
            if (mem_wreg && !mem_vf && (mem_rd == a))      src_val[s] = pack_scalar(mem_data[VW-1 -: LANE_W]);
            else if (wb_en && !wb_vf && (wb_rd == a))      src_val[s] = pack_scalar(wb_data[VW-1 -: LANE_W]);
            else if (int'(a) < NREG)                       src_val[s] = pack_scalar(srf_q[a]);
         end
      end
   end

   idex_t dec;

   always_comb begin
      dec       = '0;
      dec.valid = 1'b1;
      dec.vf    = eff_vf;
      dec.rd    = rd;
      dec.opa   = src_val[0];
      dec.opb   = src_val[1];
      dec.opc   = src_val[1];
      case (op)
         OP_ALU: begin
            dec.alu_op = {1'b0, inst};
            dec.wreg   = 1'b1;
         end
         OP_ALUI: begin
            dec.alu_op = {1'b1, inst};
            dec.wreg   = 1'b1;
            dec.opb    = pack_scalar(LANE_W'(imm));
         end
         OP_MEM: begin
            dec.rmem = ~inst[0];
            dec.wreg = ~inst[0];
            dec.wmem = inst[0];
            dec.opb  = pack_scalar(LANE_W'(signed'(imm)));
         end
         default: begin
            dec.opb = pack_scalar(LANE_W'(signed'(imm)));
            case (inst)
               2'b00: begin dec.jmp_f = 2'b01; dec.opa = pack_scalar(LANE_W'(pc)); end
               2'b01: begin
                  dec.jmp_f   = 2'b10;
                  dec.cond_en = 1'b1;
                  dec.opa     = pack_scalar(LANE_W'(pc));
               end
               2'b10:   dec.jmp_f = 2'b11;
               default: ;
            endcase
         end
      endcase
   end

   idex_t idex_d, idex_q;
   logic  hit_rs1, hit_rs2, hazard;

   // Scalar R0 never creates a dependency since it is never written.
   always_comb begin
      hit_rs1 = use_rs1 && (idex_q.rd == rs1) && (eff_vf || (rs1 != '0));
      hit_rs2 = use_rs2 && (idex_q.rd == rs2) && (eff_vf || (rs2 != '0));
      hazard  = in_valid && idex_q.valid && idex_q.rmem &&
                (idex_q.vf == eff_vf) && (hit_rs1 || hit_rs2);
   end

   always_comb begin
      idex_d = idex_q;
      if (flush)                      idex_d = '0;
      else if (ex_stall)              idex_d = idex_q;
      else if (hazard || !in_valid)   idex_d = '0;
      else                            idex_d = dec;
   end

   // NOTE: sequential state uses non-blocking assignments so every flop
   // samples pre-edge values regardless of process ordering.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) idex_q <= '0;
      else        idex_q <= idex_d;
   end

   assign stall_o   = rst_n & (hazard | ex_stall);
   assign out_valid = idex_q.valid;
   assign vf        = idex_q.vf;
   assign wmem      = idex_q.wmem;
   assign rmem      = idex_q.rmem;
   assign wreg      = idex_q.wreg;
   assign cond_en   = idex_q.cond_en;
   assign jmp_f     = idex_q.jmp_f;
   assign alu_op    = idex_q.alu_op;
   assign opa       = idex_q.opa;
   assign opb       = idex_q.opb;
   assign opc       = idex_q.opc;
   assign rd_o      = idex_q.rd;

endmodule
